inst_queue: RTL and testbench

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue_pkg.sv | 7 +
 rtl/inst_queue.sv | 93 +++++++++
 tb/tb_inst_queue.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_queue_pkg.sv
// Shared configuration constants for the instruction queue:
// default PC and instruction widths, and the all-zero bubble word.
package inst_queue_pkg;
  localparam int Addrlen = 32;
  localparam int Instlen = 32;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;
endpackage

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of {pc, inst} entries.
// Define INST_QUEUE_BYPASS_EN to let an empty queue forward fetch straight to decode.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int ADDR_W = Addrlen,
  parameter int INST_W = Instlen,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       stall_in,
  input  logic                       if_valid,
  input  logic [ADDR_W-1:0]          if_pc,
  input  logic [INST_W-1:0]          if_inst,
  output logic                       if_ready,
  output logic                       id_valid,
  output logic [ADDR_W-1:0]          id_pc,
  output logic [INST_W-1:0]          id_inst,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              q_valid;
  logic              push;
  logic              pop;

  assign q_valid  = (count != '0);
  assign if_ready = (count < CNT_W'(DEPTH));
  assign pop      = q_valid & ~stall_in & ~flush;

`ifdef INST_QUEUE_BYPASS_EN
  logic byp;

  // An empty queue forwards fetch directly; the entry is only stored if decode stalls.
  assign byp      = ~q_valid & if_valid & ~flush;
  assign push     = if_valid & if_ready & ~flush & ~(byp & ~stall_in);
  assign id_valid = q_valid | byp;

  always_comb begin
    id_pc   = ADDR_W'(ZeroWord);
    id_inst = INST_W'(ZeroWord);
    if (q_valid) begin
      id_pc   = pc_mem[rd_ptr];
      id_inst = inst_mem[rd_ptr];
    end else if (byp) begin
      id_pc   = if_pc;
      id_inst = if_inst;
    end
  end
`else
  assign push     = if_valid & if_ready & ~flush;
  assign id_valid = q_valid;
  assign id_pc    = q_valid ? pc_mem[rd_ptr]   : ADDR_W'(ZeroWord);
  assign id_inst  = q_valid ? inst_mem[rd_ptr] : INST_W'(ZeroWord);
`endif

  // Storage is never reset: an empty queue masks whatever it holds.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= if_pc;
      inst_mem[wr_ptr] <= if_inst;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: fill, drain order, flush, pointer wrap,
// asynchronous reset and the empty-queue path with or without INST_QUEUE_BYPASS_EN.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        stall_in;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [2:0]  count;

  int vectors     = 0;
  int miscompares = 0;

  inst_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .stall_in (stall_in),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_ready (if_ready),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; stall_in = 1'b0;
    if_valid = 1'b0; if_pc = '0; if_inst = '0;
    #3;
    check("rst_count",    count,    0);
    check("rst_id_valid", id_valid, 0);
    check("rst_id_pc",    id_pc,    0);
    check("rst_id_inst",  id_inst,  0);
    check("rst_if_ready", if_ready, 1);
    step();
    rst = 1'b1;

    // Fill under stall: four accepted, the fifth is held back.
    stall_in = 1'b1;
    if_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_pc   = 32'(4 * i);
      if_inst = 32'h1000 + 32'(i);
      step();
      check("fill_count", count, 64'(i + 1));
    end
    if_pc   = 32'h10;
    if_inst = 32'h1004;
    #1;
    check("full_count",    count,    4);
    check("full_if_ready", if_ready, 0);
    check("full_id_pc",    id_pc,    32'h0);
    check("full_id_inst",  id_inst,  32'h1000);
    step();
    check("full_hold_count", count, 4);
    check("full_hold_id_pc", id_pc, 32'h0);

    // Drain: 0x10 is pushed once space opens, then everything pops in order.
    stall_in = 1'b0;
    step();
    check("drain_pc1",    id_pc, 32'h4);
    check("drain_count1", count, 3);
    check("drain_ready",  if_ready, 1);
    step();
    if_valid = 1'b0;
    check("drain_pc2",    id_pc, 32'h8);
    check("drain_count2", count, 3);
    step();
    check("drain_pc3", id_pc, 32'hC);
    step();
    check("drain_pc4",   id_pc,   32'h10);
    check("drain_inst4", id_inst, 32'h1004);
    check("drain_count4", count,  1);
    step();
    check("drain_empty_valid", id_valid, 0);
    check("drain_empty_inst",  id_inst,  0);
    check("drain_empty_count", count,    0);

    // Flush at count=3 with a same-cycle push.
    stall_in = 1'b1;
    if_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_pc   = 32'h100 + 32'(4 * i);
      if_inst = 32'h2000 + 32'(i);
      step();
    end
    check("pre_flush_count", count, 3);
    flush    = 1'b1;
    stall_in = 1'b0;
    if_pc    = 32'h200;
    if_inst  = 32'h3000;
    step();
    flush    = 1'b0;
    if_valid = 1'b0;
    #1;
    check("flush_count",    count,    0);
    check("flush_id_valid", id_valid, 0);
    check("flush_id_inst",  id_inst,  0);
    check("flush_id_pc",    id_pc,    0);
    step();
    check("flush_dropped_count", count, 0);

    // Ten push/pop pairs at count=1, crossing the pointer wrap twice.
    stall_in = 1'b1;
    if_valid = 1'b1;
    if_pc    = 32'h400;
    if_inst  = 32'h4000;
    step();
    check("wrap_prime_count", count, 1);
    stall_in = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if_pc   = 32'h400 + 32'(4 * k);
      if_inst = 32'h4000 + 32'(k);
      #1;
      check("wrap_count", count, 1);
      check("wrap_id_pc", id_pc, 64'(32'h400 + 32'(4 * (k - 1))));
      step();
    end
    if_valid = 1'b0;
    #1;
    check("wrap_end_count", count,   1);
    check("wrap_end_pc",    id_pc,   32'h428);
    check("wrap_end_inst",  id_inst, 32'h400A);
    step();
    check("wrap_drained", count, 0);

    // Asynchronous reset at count=2, between clock edges.
    stall_in = 1'b1;
    if_valid = 1'b1;
    if_pc    = 32'h500;
    step();
    if_pc    = 32'h504;
    step();
    if_valid = 1'b0;
    check("pre_areset_count", count, 2);
    #1;
    rst = 1'b0;
    #1;
    check("areset_count",    count,    0);
    check("areset_id_valid", id_valid, 0);
    check("areset_id_pc",    id_pc,    0);
    check("areset_if_ready", if_ready, 1);
    step();
    rst      = 1'b1;
    stall_in = 1'b0;
    #1;
    check("post_areset_count", count, 0);

    // Empty queue, push 0x40 with decode ready.
    if_valid = 1'b1;
    if_pc    = 32'h40;
    if_inst  = 32'hABC;
    #1;
`ifdef INST_QUEUE_BYPASS_EN
    check("byp_id_valid", id_valid, 1);
    check("byp_id_pc",    id_pc,    32'h40);
    check("byp_id_inst",  id_inst,  32'hABC);
    step();
    if_valid = 1'b0;
    #1;
    check("byp_count",    count,    0);
    check("byp_id_valid_after", id_valid, 0);
`else
    check("nobyp_id_valid_same", id_valid, 0);
    check("nobyp_id_pc_same",    id_pc,    0);
    step();
    if_valid = 1'b0;
    #1;
    check("nobyp_id_pc_next",   id_pc,    32'h40);
    check("nobyp_id_inst_next", id_inst,  32'hABC);
    check("nobyp_count_next",   count,    1);
    step();
    check("nobyp_drained", count, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
